// File: rtl/deframe.sv
// Frame decoder behind the UART receiver: SYNC, LEN, payload, CHECKSUM.
// Payload bytes are forwarded through a one-byte hold so the final byte can carry the checksum verdict.
module deframe #(
  parameter logic [7:0]  SYNC = 8'hA5,
  parameter int unsigned MAX  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic [7:0] dat,
  output logic       rdy,
  output logic       ostb,
  output logic [7:0] odat,
  output logic       olst,
  output logic       oerr,
  input  logic       ordy,
  output logic       drop
);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_SUM} state_t;

  localparam logic [7:0] MAX_B = 8'(MAX);

  state_t     state, state_nxt;
  logic [7:0] sum, cnt;
  logic [7:0] hold_p0;
  logic       vld_p0;
  logic       acc, out_free, move;
  logic [7:0] total;

  function automatic logic [7:0] add_mod(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (acc && dat == SYNC) state_nxt = S_LEN;
      S_LEN:
        if (acc) begin
          if (dat > MAX_B)      state_nxt = S_IDLE;
          else if (dat == 8'd0) state_nxt = S_SUM;
          else                  state_nxt = S_DATA;
        end
      S_DATA: if (acc && cnt == 8'd1) state_nxt = S_SUM;
      S_SUM:  if (acc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The hold can only shift into the output register when that register is empty or draining.
  always_comb begin
    out_free = !ostb || ordy;
    rdy      = !rst && (state == S_IDLE || state == S_LEN || !vld_p0 || out_free);
    acc      = stb && rdy;
    total    = add_mod(sum, dat);
    move     = acc && vld_p0 && (state == S_DATA || state == S_SUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      ostb   <= 1'b0;
      odat   <= 8'd0;
      olst   <= 1'b0;
      oerr   <= 1'b0;
      drop   <= 1'b0;
      sum    <= 8'd0;
      cnt    <= 8'd0;
    end else begin
      drop <= 1'b0;
      if (move) begin
        ostb <= 1'b1;
        odat <= hold_p0;
        olst <= (state == S_SUM);
        oerr <= (state == S_SUM) && (total != 8'd0);
      end else if (ordy) begin
        ostb <= 1'b0;
      end
      if (acc) begin
        unique case (state)
          S_LEN: begin
            sum  <= dat;
            cnt  <= dat;
            drop <= (dat > MAX_B);
          end
          S_DATA: begin
            sum    <= total;
            cnt    <= cnt - 8'd1;
            vld_p0 <= 1'b1;
          end
          // An empty hold here means LEN was zero: nothing to emit, only a bad sum is reported.
          S_SUM: begin
            sum    <= total;
            vld_p0 <= 1'b0;
            drop   <= !vld_p0 && (total != 8'd0);
          end
          default: ;
        endcase
      end
    end
  end

  // ---- stage p0: payload hold (data only) ----
  always_ff @(posedge clk) begin
    if (acc && state == S_DATA) hold_p0 <= dat;
  end

endmodule

// File: tb/tb_deframe.sv
// Bench for deframe: fixed frame vectors, hand-timed corner sequences, and random frames against a parser model.
`timescale 1ns/1ps
module tb_deframe;

  localparam int MAXL = 64;

  logic       clk = 1'b0;
  logic       rst, stb, ordy, rdy, ostb, olst, oerr, drop;
  logic [7:0] dat, odat;

  logic       bp, ordy_force, rdy_low;
  int         total = 0;
  int         bad   = 0;
  int         drops;
  logic [9:0] oq[$];
  logic [9:0] exp_q[$];
  logic [7:0] gen_q[$];
  int         exp_drops;

  typedef struct {
    logic [127:0] ib;
    int           nin;
    logic [127:0] ob;
    int           nout;
    logic         lerr;
    int           ndrop;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  deframe dut (
    .clk(clk), .rst(rst), .stb(stb), .dat(dat), .rdy(rdy),
    .ostb(ostb), .odat(odat), .olst(olst), .oerr(oerr), .ordy(ordy), .drop(drop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  initial begin
    ordy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ordy = bp ? ($urandom_range(0, 3) != 0) : ordy_force;
    end
  end

  // Output collector, stall-stability and drop-width checks.
  initial begin
    logic       pstall, pdrop;
    logic [9:0] pout;
    pstall = 1'b0; pdrop = 1'b0; pout = 10'd0; drops = 0;
    forever begin
      @(negedge clk);
      if (pstall) begin
        chk("stall_ostb", 32'(ostb), 32'd1);
        chk("stall_data", 32'({olst, oerr, odat}), 32'(pout));
      end
      if (pdrop) chk("drop_width", 32'(drop), 32'd0);
      if (!rst && ostb === 1'b1 && ordy) oq.push_back({olst, oerr, odat});
      if (!rst && drop === 1'b1) drops++;
      pstall = !rst && ostb === 1'b1 && !ordy;
      pdrop  = (drop === 1'b1);
      pout   = {olst, oerr, odat};
    end
  end

  task automatic sync_drive();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    stb = 1'b1;
    dat = b;
    @(negedge clk);
    while (!rdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!rdy) chk("rdy_timeout", 32'(rdy), 32'd1);
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (oq.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    sync_drive();
  endtask

  task automatic gen_frames(input int nf);
    logic [7:0] len, s, b;
    for (int f = 0; f < nf; f++) begin
      int ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        gen_q.push_back(b);
      end
      gen_q.push_back(8'hA5);
      case ($urandom_range(0, 7))
        0:       len = 8'($urandom_range(MAXL + 1, 255));
        1:       len = 8'(MAXL);
        2:       len = 8'd0;
        default: len = 8'($urandom_range(1, 20));
      endcase
      gen_q.push_back(len);
      if (int'(len) > MAXL) continue;
      s = len;
      for (int k = 0; k < int'(len); k++) begin
        b = 8'($urandom_range(0, 255));
        s += b;
        gen_q.push_back(b);
      end
      b = 8'd0 - s;
      if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
      gen_q.push_back(b);
    end
  endtask

  // Reference: parse the whole byte list frame by frame.
  function automatic void run_model();
    int i = 0;
    int len;
    logic [7:0] s;
    exp_q.delete();
    exp_drops = 0;
    while (i < gen_q.size()) begin
      if (gen_q[i] != 8'hA5) begin i++; continue; end
      if (i + 1 >= gen_q.size()) break;
      len = int'(gen_q[i+1]);
      i += 2;
      if (len > MAXL) begin exp_drops++; continue; end
      if (i + len >= gen_q.size()) break;
      s = 8'(len);
      for (int k = 0; k <= len; k++) s += gen_q[i+k];
      if (len == 0) begin
        if (s != 8'd0) exp_drops++;
      end else begin
        for (int k = 0; k < len; k++)
          exp_q.push_back({k == len - 1, (k == len - 1) && (s != 8'd0), gen_q[i+k]});
      end
      i += len + 1;
    end
  endfunction

  initial begin
    vecs[0] = '{ib:128'hA50311223397,   nin:6, ob:128'h112233, nout:3, lerr:1'b0, ndrop:0};
    vecs[1] = '{ib:128'hA50311223300,   nin:6, ob:128'h112233, nout:3, lerr:1'b1, ndrop:0};
    vecs[2] = '{ib:128'h00FF5AA5017E81, nin:7, ob:128'h7E,     nout:1, lerr:1'b0, ndrop:0};
    vecs[3] = '{ib:128'hA541A50110EF,   nin:6, ob:128'h10,     nout:1, lerr:1'b0, ndrop:1};
    vecs[4] = '{ib:128'hA50000,         nin:3, ob:128'h0,      nout:0, lerr:1'b0, ndrop:0};
    vecs[5] = '{ib:128'hA50001,         nin:3, ob:128'h0,      nout:0, lerr:1'b0, ndrop:1};
    vecs[6] = '{ib:128'hA502A5A5B4,     nin:5, ob:128'hA5A5,   nout:2, lerr:1'b0, ndrop:0};
    vecs[7] = '{ib:128'hA5014200,       nin:4, ob:128'h42,     nout:1, lerr:1'b1, ndrop:0};

    rst = 1'b1; stb = 1'b0; dat = 8'd0; bp = 1'b0; ordy_force = 1'b1; rdy_low = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ostb", 32'(ostb), 32'd0);
    chk("rst_odat", 32'(odat), 32'd0);
    chk("rst_olst", 32'(olst), 32'd0);
    chk("rst_oerr", 32'(oerr), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_rdy_low", 32'(rdy), 32'd0);
    sync_drive();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy_after", 32'(rdy), 32'd1);
    sync_drive();

    for (int v = 0; v < NV; v++) begin
      logic [127:0] ib, ob;
      int ni, no;
      ib = vecs[v].ib; ob = vecs[v].ob; ni = vecs[v].nin; no = vecs[v].nout;
      oq.delete();
      drops = 0;
      for (int i = 0; i < ni; i++) send_byte(ib[8*(ni-1-i) +: 8]);
      drain(no);
      chk($sformatf("v%0d_count", v), 32'(oq.size()), 32'(no));
      for (int i = 0; i < no && i < oq.size(); i++) begin
        chk($sformatf("v%0d_dat%0d", v, i), 32'(oq[i][7:0]), 32'(ob[8*(no-1-i) +: 8]));
        chk($sformatf("v%0d_lst%0d", v, i), 32'(oq[i][9]), 32'(i == no - 1));
        if (i == no - 1) chk($sformatf("v%0d_err", v), 32'(oq[i][8]), 32'(vecs[v].lerr));
      end
      chk($sformatf("v%0d_drops", v), 32'(drops), 32'(vecs[v].ndrop));
    end

    // Drop timing on an oversize LEN.
    oq.delete(); drops = 0;
    send_byte(8'hA5);
    send_byte(8'h41);
    @(negedge clk);
    chk("drop_latency", 32'(drop), 32'd1);
    sync_drive();
    drain(0);
    chk("drop_once", 32'(drops), 32'd1);

    // Backpressure mid-payload.
    oq.delete(); drops = 0; rdy_low = 1'b0;
    fork
      begin
        send_byte(8'hA5);
        send_byte(8'h08);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'hD4);
      end
      begin
        repeat (5) @(posedge clk);
        ordy_force = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (!rdy) rdy_low = 1'b1;
        end
        ordy_force = 1'b1;
      end
    join
    drain(8);
    chk("stall_rdy_low", 32'(rdy_low), 32'd1);
    chk("stall_count", 32'(oq.size()), 32'd8);
    for (int i = 0; i < 8 && i < oq.size(); i++) begin
      chk($sformatf("stall_dat%0d", i), 32'(oq[i][7:0]), 32'(i + 1));
      chk($sformatf("stall_lst%0d", i), 32'(oq[i][9]), 32'(i == 7));
    end
    if (oq.size() == 8) chk("stall_err", 32'(oq[7][8]), 32'd0);
    chk("stall_drops", 32'(drops), 32'd0);

    // Reset in the middle of a frame with a pending output byte.
    oq.delete(); drops = 0;
    ordy_force = 1'b0;
    sync_drive();
    sync_drive();
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    chk("lat_ostb", 32'(ostb), 32'd1);
    chk("lat_odat", 32'(odat), 32'hAA);
    sync_drive();
    rst = 1'b1;
    sync_drive();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ostb", 32'(ostb), 32'd0);
    chk("mid_rst_rdy", 32'(rdy), 32'd1);
    ordy_force = 1'b1;
    sync_drive();
    sync_drive();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'hAA);
    @(negedge clk);
    chk("last_lat_ostb", 32'(ostb), 32'd1);
    chk("last_lat_odat", 32'(odat), 32'h55);
    chk("last_lat_olst", 32'(olst), 32'd1);
    chk("last_lat_oerr", 32'(oerr), 32'd0);
    sync_drive();
    drain(1);
    chk("mid_rst_count", 32'(oq.size()), 32'd1);
    chk("mid_rst_drops", 32'(drops), 32'd0);

    // Random frames under random backpressure.
    for (int r = 0; r < 2; r++) begin
      gen_q.delete();
      gen_frames(40);
      run_model();
      oq.delete(); drops = 0;
      bp = 1'b1;
      for (int i = 0; i < gen_q.size(); i++) send_byte(gen_q[i]);
      bp = 1'b0;
      ordy_force = 1'b1;
      drain(exp_q.size());
      chk($sformatf("r%0d_count", r), 32'(oq.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < oq.size(); i++) begin
        chk($sformatf("r%0d_dat%0d", r, i), 32'(oq[i][7:0]), 32'(exp_q[i][7:0]));
        chk($sformatf("r%0d_lst%0d", r, i), 32'(oq[i][9]), 32'(exp_q[i][9]));
        if (exp_q[i][9]) chk($sformatf("r%0d_err%0d", r, i), 32'(oq[i][8]), 32'(exp_q[i][8]));
      end
      chk($sformatf("r%0d_drops", r), 32'(drops), 32'(exp_drops));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
